pal_line_padder: RTL and testbench

PAL_LINE_PADDER -- requirements
Module: pal_line_padder

---
 rtl/pal_line_padder.sv | 129 ++++++++++++
 tb/tb_pal_line_padder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_line_padder.sv
// Inserts synthetic blank lines into each PAL field: after a set number of lines past
// field sync, the VDG is frozen and horizontal sync is generated locally.
//
// state | meaning
// IDLE  | pass-through, waiting for a field sync edge
// COUNT | counting HSb falling edges after field sync
// PAD   | VDG frozen, synthetic lines with local sync pulses
module pal_line_padder #(
  parameter int LINE_CLKS  = 228,
  parameter int SYNC_CLKS  = 17,
  parameter int SKIP_LINES = 24,
  parameter int PAD_LINES  = 25
) (
  input  logic VCLK,
  input  logic RST,
  input  logic Format,
  input  logic HSb,
  input  logic FSb,
  output logic NHSb,
  output logic CLKEN,
  output logic LUMAC,
  output logic LPulse,
  output logic PADDING,
  output logic PAD_DONE
);

  typedef enum logic [1:0] {IDLE, COUNT, PAD} state_t;

  localparam int TW = $clog2(LINE_CLKS);
  localparam int PW = (PAD_LINES > 1) ? $clog2(PAD_LINES) : 1;
  localparam int LW = (SKIP_LINES > 1) ? $clog2(SKIP_LINES) : 1;

  state_t        state;
  logic [2:0]    hs_sync;
  logic [2:0]    fs_sync;
  logic [TW-1:0] timer;
  logic [PW-1:0] pad_cnt;
  logic [LW-1:0] line_cnt;
  logic          done_pend;
  logic          hs_fall;
  logic          fs_fall;
  logic          pad_active;
  logic          sync_low;

  assign hs_fall    = hs_sync[2] & ~hs_sync[1];
  assign fs_fall    = fs_sync[2] & ~fs_sync[1];
  // Format and a new field both end padding on the very next output update.
  assign pad_active = (state == PAD) && !Format && !fs_fall;
  assign sync_low   = pad_active && (timer < TW'(SYNC_CLKS));

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      hs_sync <= '1;
      fs_sync <= '1;
    end else begin
      hs_sync <= {hs_sync[1:0], HSb};
      fs_sync <= {fs_sync[1:0], FSb};
    end
  end

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      timer     <= '0;
      pad_cnt   <= '0;
      line_cnt  <= '0;
      done_pend <= 1'b0;
    end else begin
      done_pend <= 1'b0;
      if (Format) begin
        state <= IDLE;
      end else if (fs_fall) begin
        state    <= (SKIP_LINES == 0) ? PAD : COUNT;
        line_cnt <= '0;
        timer    <= '0;
        pad_cnt  <= '0;
      end else begin
        case (state)
          COUNT: begin
            if (hs_fall) begin
              if (line_cnt == LW'(SKIP_LINES - 1)) begin
                state   <= PAD;
                timer   <= '0;
                pad_cnt <= '0;
              end else begin
                line_cnt <= line_cnt + 1'b1;
              end
            end
          end
          PAD: begin
            if (timer == TW'(LINE_CLKS - 1)) begin
              timer <= '0;
              if (pad_cnt == PW'(PAD_LINES - 1)) begin
                state     <= IDLE;
                pad_cnt   <= '0;
                done_pend <= 1'b1;
              end else begin
                pad_cnt <= pad_cnt + 1'b1;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs trail the state by one register so PAD_DONE lands right after PADDING falls.
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      NHSb     <= 1'b1;
      CLKEN    <= 1'b1;
      LUMAC    <= 1'b0;
      LPulse   <= 1'b0;
      PADDING  <= 1'b0;
      PAD_DONE <= 1'b0;
    end else begin
      PADDING  <= pad_active;
      CLKEN    <= !pad_active;
      LUMAC    <= pad_active;
      LPulse   <= sync_low;
      NHSb     <= pad_active ? !sync_low : hs_sync[1];
      PAD_DONE <= done_pend;
    end
  end

endmodule

// File: tb/tb_pal_line_padder.sv
// Self-checking bench for pal_line_padder: vector table, pass-through scoreboard,
// and hand-written pad/restart/reset/abort sequences.
module tb_pal_line_padder;

  localparam int LC = 16;
  localparam int SC = 4;
  localparam int SK = 2;
  localparam int PL = 3;

  logic VCLK = 1'b0;
  logic RST = 1'b1;
  logic Format = 1'b0;
  logic HSb = 1'b1;
  logic FSb = 1'b1;
  logic NHSb, CLKEN, LUMAC, LPulse, PADDING, PAD_DONE;
  logic u1_nhsb, u1_clken, u1_lumac, u1_lpulse, u1_padding, u1_done;

  pal_line_padder #(.LINE_CLKS(LC), .SYNC_CLKS(SC), .SKIP_LINES(SK), .PAD_LINES(PL)) u0 (
    .VCLK(VCLK), .RST(RST), .Format(Format), .HSb(HSb), .FSb(FSb),
    .NHSb(NHSb), .CLKEN(CLKEN), .LUMAC(LUMAC), .LPulse(LPulse),
    .PADDING(PADDING), .PAD_DONE(PAD_DONE)
  );

  pal_line_padder #(.LINE_CLKS(LC), .SYNC_CLKS(SC), .SKIP_LINES(0), .PAD_LINES(PL)) u1 (
    .VCLK(VCLK), .RST(RST), .Format(Format), .HSb(HSb), .FSb(FSb),
    .NHSb(u1_nhsb), .CLKEN(u1_clken), .LUMAC(u1_lumac), .LPulse(u1_lpulse),
    .PADDING(u1_padding), .PAD_DONE(u1_done)
  );

  always #5 VCLK = ~VCLK;

  typedef struct {
    bit fmt;
    bit h;
    bit f;
    int n;
    bit exp_pad;
    bit exp_clken;
    bit exp_lpulse;
  } vec_t;

  typedef struct {
    int due;
    bit val;
  } sb_t;

  sb_t  sbq[$];
  vec_t vt[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   pad_run = 0;
  int   last_len = 0;
  int   pad_starts = 0;
  int   done_total = 0;
  int   done_at_fall = 0;

  always @(posedge VCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for u0: per-cycle pad shape, run lengths, PAD_DONE, and scoreboard pops.
  always @(negedge VCLK) begin
    if (PADDING) begin
      if (pad_run == 0) pad_starts++;
      chk("pad_clken", CLKEN, 0);
      chk("pad_lumac", LUMAC, 1);
      chk("pad_nhsb", NHSb, ((pad_run % LC) < SC) ? 0 : 1);
      chk("pad_lpulse", LPulse, ((pad_run % LC) < SC) ? 1 : 0);
      pad_run++;
    end else begin
      chk("idle_clken", CLKEN, 1);
      chk("idle_lumac", LUMAC, 0);
      chk("idle_lpulse", LPulse, 0);
      if (pad_run != 0) begin
        last_len     = pad_run;
        done_at_fall = PAD_DONE;
        pad_run      = 0;
      end
    end
    if (PAD_DONE) done_total++;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      chk("passthru_nhsb", NHSb, sbq[0].val);
      void'(sbq.pop_front());
    end
  end

  task automatic drive(input bit fmt, input bit h, input bit f);
    @(posedge VCLK);
    #1;
    Format = fmt;
    HSb    = h;
    FSb    = f;
    if (fmt) sbq.push_back('{due: cyc + 3, val: h});
  endtask

  task automatic run(input int n, input bit fmt, input bit h, input bit f);
    for (int i = 0; i < n; i++) drive(fmt, h, f);
  endtask

  task automatic hs_pulse();
    run(4, 0, 0, 1);
    run(10, 0, 1, 1);
  endtask

  // Call right after the 4-cycle HSb low that should start padding.
  task automatic wait_pad(input string nm);
    int k;
    k = 0;
    @(negedge VCLK);
    while (!PADDING && k < 200) begin
      @(negedge VCLK);
      k++;
    end
    chk(nm, PADDING, 1);
    chk({nm, "_latency"}, k, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, cnt, dn;

    // reset values
    repeat (3) @(negedge VCLK);
    chk("rst_nhsb", NHSb, 1);
    chk("rst_clken", CLKEN, 1);
    chk("rst_lumac", LUMAC, 0);
    chk("rst_lpulse", LPulse, 0);
    chk("rst_padding", PADDING, 0);
    chk("rst_pad_done", PAD_DONE, 0);
    chk("rst_u1_padding", u1_padding, 0);
    #2 RST = 1'b0;
    run(4, 0, 1, 1);

    // zero skip (u1): padding four cycles after the FSb pin edge
    drive(0, 1, 0);
    repeat (4) @(negedge VCLK);
    chk("zs_pad_early", u1_padding, 0);
    @(negedge VCLK);
    chk("zs_pad_rise", u1_padding, 1);
    chk("zs_nhsb", u1_nhsb, 0);
    chk("zs_clken", u1_clken, 0);
    chk("zs_lumac", u1_lumac, 1);
    chk("zs_lpulse", u1_lpulse, 1);
    cnt = 1;
    dn  = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge VCLK);
      cnt += int'(u1_padding);
      dn  += int'(u1_done);
    end
    chk("zs_len", cnt, LC * PL);
    chk("zs_done", dn, 1);
    run(2, 0, 1, 1);

    // vector table: NTSC pass-through, then a PAL pad aborted by Format
    vt.push_back('{1, 1, 1, 8, 0, 1, 0});
    vt.push_back('{1, 1, 0, 4, 0, 1, 0});
    vt.push_back('{1, 1, 1, 8, 0, 1, 0});
    vt.push_back('{1, 0, 1, 4, 0, 1, 0});
    vt.push_back('{1, 1, 1, 12, 0, 1, 0});
    vt.push_back('{1, 0, 1, 4, 0, 1, 0});
    vt.push_back('{1, 1, 1, 12, 0, 1, 0});
    vt.push_back('{1, 0, 1, 4, 0, 1, 0});
    vt.push_back('{1, 1, 1, 12, 0, 1, 0});
    vt.push_back('{1, 1, 1, 20, 0, 1, 0});
    vt.push_back('{0, 1, 0, 3, 0, 1, 0});
    vt.push_back('{0, 1, 1, 8, 0, 1, 0});
    vt.push_back('{0, 0, 1, 4, 0, 1, 0});
    vt.push_back('{0, 1, 1, 8, 0, 1, 0});
    vt.push_back('{0, 0, 1, 4, 0, 1, 0});
    vt.push_back('{0, 1, 1, 17, 1, 0, 1});
    vt.push_back('{1, 1, 1, 4, 0, 1, 0});
    d0 = done_total;
    for (int i = 0; i < vt.size(); i++) begin
      run(vt[i].n, vt[i].fmt, vt[i].h, vt[i].f);
      @(negedge VCLK);
      chk("vec_padding", PADDING, vt[i].exp_pad);
      chk("vec_clken", CLKEN, vt[i].exp_clken);
      chk("vec_lpulse", LPulse, vt[i].exp_lpulse);
    end
    chk("vec_no_done", done_total - d0, 0);

    // nominal pad, with an HSb pulse inside PAD that must be ignored
    d0 = done_total;
    run(5, 0, 1, 1);
    run(3, 0, 1, 0);
    run(8, 0, 1, 1);
    hs_pulse();
    @(negedge VCLK);
    chk("nom_one_line_no_pad", PADDING, 0);
    run(4, 0, 0, 1);
    wait_pad("nom_pad_start");
    run(10, 0, 1, 1);
    hs_pulse();
    run(60, 0, 1, 1);
    chk("nom_len", last_len, LC * PL);
    chk("nom_done_count", done_total - d0, 1);
    chk("nom_done_after", done_at_fall, 1);

    // FSb and HSb edges flagged together: field restart wins, no pad
    s0 = pad_starts;
    run(3, 0, 1, 0);
    run(8, 0, 1, 1);
    hs_pulse();
    run(4, 0, 0, 0);
    run(30, 0, 1, 1);
    chk("prio_no_pad", pad_starts - s0, 0);

    // field restart at pad cycle 20
    d0 = done_total;
    run(3, 0, 1, 0);
    run(8, 0, 1, 1);
    hs_pulse();
    run(4, 0, 0, 1);
    wait_pad("fr_pad_start");
    run(16, 0, 1, 1);
    run(3, 0, 1, 0);
    run(8, 0, 1, 1);
    chk("fr_len", last_len, 20);
    chk("fr_no_done", done_total - d0, 0);
    hs_pulse();
    @(negedge VCLK);
    chk("fr_one_line_no_pad", PADDING, 0);
    run(4, 0, 0, 1);
    wait_pad("fr_repad_start");
    run(60, 0, 1, 1);
    chk("fr_repad_len", last_len, LC * PL);
    chk("fr_repad_done", done_total - d0, 1);

    // reset at pad cycle 10
    d0 = done_total;
    run(3, 0, 1, 0);
    run(8, 0, 1, 1);
    hs_pulse();
    run(4, 0, 0, 1);
    wait_pad("rp_pad_start");
    run(9, 0, 1, 1);
    @(negedge VCLK);
    #2 RST = 1'b1;
    #1;
    chk("rp_clken", CLKEN, 1);
    chk("rp_nhsb", NHSb, 1);
    chk("rp_padding", PADDING, 0);
    chk("rp_lumac", LUMAC, 0);
    chk("rp_lpulse", LPulse, 0);
    repeat (2) @(negedge VCLK);
    #2 RST = 1'b0;
    run(20, 0, 1, 1);
    chk("rp_len", last_len, 10);
    chk("rp_no_done", done_total - d0, 0);

    // Format abort at pad cycle 30, then NHSb tracks HSb via the scoreboard
    d0 = done_total;
    run(3, 0, 1, 0);
    run(8, 0, 1, 1);
    hs_pulse();
    run(4, 0, 0, 1);
    wait_pad("fa_pad_start");
    run(28, 0, 1, 1);
    drive(1, 1, 1);
    @(negedge VCLK);
    @(negedge VCLK);
    chk("fa_clken", CLKEN, 1);
    chk("fa_padding", PADDING, 0);
    for (int i = 0; i < 3; i++) begin
      run(4, 1, 0, 1);
      run(12, 1, 1, 1);
    end
    run(6, 1, 1, 1);
    chk("fa_len", last_len, 30);
    chk("fa_no_done", done_total - d0, 0);

    run(6, 0, 1, 1);
    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
